// File: rtl/fifo.sv
// Packet FIFO: DEPTH slots of WIDTH bytes, byte-addressed write into the open slot, byte-addressed read of the head.
// Optional build macro FIFO_LEN_CHECK_EN gates each commit on the packet length stored in byte 2 of the slot.
module fifo #(
    parameter int DEPTH     = 3,
    parameter int WIDTH     = 11,
    parameter int UWIDTH    = 8,
    parameter int PTR_SZ    = 2,
    parameter int PTR_IN_SZ = 4
) (
    input  logic                 clk1,
    input  logic                 rst,
    input  logic                 winc,
    input  logic [PTR_IN_SZ-1:0] waddr_in,
    input  logic [UWIDTH-1:0]    wdata,
    input  logic                 rinc,
    input  logic [PTR_IN_SZ-1:0] raddr_in,
    output logic [UWIDTH-1:0]    rdata,
    output logic                 wfull,
    output logic                 rempty
);

    localparam logic [PTR_SZ:0]    COUNT_MAX  = (PTR_SZ+1)'(DEPTH);
    localparam logic [PTR_SZ:0]    COUNT_ONE  = {{PTR_SZ{1'b0}}, 1'b1};
    localparam logic [PTR_SZ-1:0]  LAST_SLOT  = PTR_SZ'(DEPTH - 32'sd1);
    localparam logic [PTR_SZ-1:0]  SLOT_ONE   = {{(PTR_SZ-1){1'b0}}, 1'b1};
    localparam logic [PTR_IN_SZ:0] SLOT_BYTES = (PTR_IN_SZ+1)'(WIDTH);

    typedef enum logic {
        ACCEPT = 1'b0,
        FULL   = 1'b1
    } wstate_t;

    logic [UWIDTH-1:0] mem [DEPTH][WIDTH];

    logic [PTR_SZ-1:0] wptr_r;
    logic [PTR_SZ-1:0] rptr_r;
    logic [PTR_SZ:0]   count_r;
    logic [PTR_SZ:0]   count_next_s;
    wstate_t           state_r;
    wstate_t           state_next_s;
    logic              wr_en_s;
    logic              rd_ok_s;
    logic              len_ok_s;
    logic              commit_s;
    logic              pop_s;

    function automatic logic [PTR_SZ-1:0] next_slot(input logic [PTR_SZ-1:0] p);
        return (p == LAST_SLOT) ? {PTR_SZ{1'b0}} : p + SLOT_ONE;
    endfunction

    assign wfull    = (count_r == COUNT_MAX);
    assign rempty   = (count_r == {(PTR_SZ+1){1'b0}});
    assign wr_en_s  = !wfull  && ({1'b0, waddr_in} < SLOT_BYTES);
    assign rd_ok_s  = !rempty && ({1'b0, raddr_in} < SLOT_BYTES);
    assign commit_s = winc && !wfull && len_ok_s;
    assign pop_s    = rinc && !rempty;

`ifdef FIFO_LEN_CHECK_EN
    localparam logic [PTR_IN_SZ-1:0] SIZE_IDX = PTR_IN_SZ'(2'd2);
    logic [UWIDTH:0] len_target_s;
    // The CRC byte sits at size+3, so the committing write must land exactly there.
    assign len_target_s = {1'b0, mem[wptr_r][SIZE_IDX]} + (UWIDTH+1)'(2'd3);
    assign len_ok_s     = (len_target_s == (UWIDTH+1)'(waddr_in));
`else
    assign len_ok_s = 1'b1;
`endif

    // Byte writes into the open slot; storage is deliberately not reset.
    always_ff @(posedge clk1) begin
        if (wr_en_s) begin
            mem[wptr_r][waddr_in] <= wdata;
        end
    end

    // Occupancy update from the commit/pop pair.
    always_comb begin
        count_next_s = count_r;
        case ({commit_s, pop_s})
            2'b10:   count_next_s = count_r + COUNT_ONE;
            2'b01:   count_next_s = count_r - COUNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Write-side state: FULL is entered only by the commit that fills the last slot.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ACCEPT: begin
                if (commit_s && !pop_s && (count_r == COUNT_MAX - COUNT_ONE)) begin
                    state_next_s = FULL;
                end else begin
                    state_next_s = ACCEPT;
                end
            end
            FULL: begin
                if (pop_s) begin
                    state_next_s = ACCEPT;
                end else begin
                    state_next_s = FULL;
                end
            end
            default: state_next_s = ACCEPT;
        endcase
    end

    // Pointers, occupancy, state and the registered read byte.
    always_ff @(posedge clk1) begin
        if (rst) begin
            wptr_r  <= {PTR_SZ{1'b0}};
            rptr_r  <= {PTR_SZ{1'b0}};
            count_r <= {(PTR_SZ+1){1'b0}};
            state_r <= ACCEPT;
            rdata   <= {UWIDTH{1'b0}};
        end else begin
            wptr_r  <= commit_s ? next_slot(wptr_r) : wptr_r;
            rptr_r  <= pop_s ? next_slot(rptr_r) : rptr_r;
            count_r <= count_next_s;
            state_r <= state_next_s;
            rdata   <= rd_ok_s ? mem[rptr_r][raddr_in] : {UWIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_fifo.sv
// Directed self-checking bench for the packet FIFO; the length-check scenario runs only when FIFO_LEN_CHECK_EN is defined.
module tb_fifo;

    logic       clk1;
    logic       rst;
    logic       winc;
    logic [3:0] waddr_in;
    logic [7:0] wdata;
    logic       rinc;
    logic [3:0] raddr_in;
    logic [7:0] rdata;
    logic       wfull;
    logic       rempty;

    int n_checks;
    int n_pass;

    fifo dut (
        .clk1     (clk1),
        .rst      (rst),
        .winc     (winc),
        .waddr_in (waddr_in),
        .wdata    (wdata),
        .rinc     (rinc),
        .raddr_in (raddr_in),
        .rdata    (rdata),
        .wfull    (wfull),
        .rempty   (rempty)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    // bytes holds the packet in natural order, first byte in the most significant used position
    task automatic write_pkt(input logic [127:0] bytes, input int n, input logic do_commit);
        for (int i = 0; i < n; i++) begin
            waddr_in = 4'(i);
            wdata    = bytes[8*(n-1-i) +: 8];
            winc     = do_commit && (i == n - 1);
            step();
        end
        winc = 1'b0;
    endtask

    task automatic read_at(input logic [3:0] addr);
        raddr_in = addr;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1; winc = 1'b0; rinc = 1'b0;
        waddr_in = 4'd0; wdata = 8'd0; raddr_in = 4'd0;
        step();
        step();
        check("reset_rempty", 8'(rempty), 8'd1);
        check("reset_wfull",  8'(wfull),  8'd0);
        check("reset_rdata",  rdata,      8'd0);
        rst = 1'b0;

        // first packet, committed on its CRC byte
        write_pkt(128'({8'd10, 8'd160, 8'd3, 8'd0, 8'd1, 8'd2, 8'd15}), 7, 1'b1);
        check("a_rempty", 8'(rempty), 8'd0);
        check("a_wfull",  8'(wfull),  8'd0);
        read_at(4'd1);
        check("a_dest", rdata, 8'd160);
        read_at(4'd6);
        check("a_crc", rdata, 8'd15);
        read_at(4'd11);
        check("a_addr_oob", rdata, 8'd0);

        write_pkt(128'({8'd100, 8'd10, 8'd4, 8'd0, 8'd1, 8'd2, 8'd3, 8'd55}), 8, 1'b1);
        check("b_wfull", 8'(wfull), 8'd0);
        write_pkt(128'({8'd255, 8'd63, 8'd5, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd55}), 9, 1'b1);
        check("c_wfull", 8'(wfull), 8'd1);

        // commit and byte write while full must both be dropped
        waddr_in = 4'd0; wdata = 8'd99; winc = 1'b1;
        step();
        winc = 1'b0;
        check("full_commit_wfull", 8'(wfull), 8'd1);
        read_at(4'd0);
        check("full_slot0_intact", rdata, 8'd10);

        rinc = 1'b1;
        step();
        rinc = 1'b0;
        check("pop_wfull", 8'(wfull), 8'd0);
        read_at(4'd0);
        check("pop_head_src", rdata, 8'd100);

        write_pkt(128'({8'd1, 8'd2, 8'd0, 8'd77}), 4, 1'b1);
        check("d_wfull", 8'(wfull), 8'd1);

        // full: simultaneous commit and pop, only the pop lands
        waddr_in = 4'd0; wdata = 8'd42; winc = 1'b1; rinc = 1'b1;
        step();
        winc = 1'b0; rinc = 1'b0;
        check("sim_full_wfull",  8'(wfull),  8'd0);
        check("sim_full_rempty", 8'(rempty), 8'd0);

        // next packet must land in the slot the write pointer held before
        write_pkt(128'({8'd7, 8'd8, 8'd0, 8'd9}), 4, 1'b1);
        check("e_wfull", 8'(wfull), 8'd1);
        read_at(4'd0);
        check("head_c", rdata, 8'd255);
        rinc = 1'b1; step(); rinc = 1'b0;
        read_at(4'd0);
        check("head_d", rdata, 8'd1);
        rinc = 1'b1; step(); rinc = 1'b0;
        read_at(4'd0);
        check("head_e", rdata, 8'd7);
        rinc = 1'b1; step(); rinc = 1'b0;
        check("drain_rempty", 8'(rempty), 8'd1);
        read_at(4'd0);
        check("empty_rdata", rdata, 8'd0);

        rinc = 1'b1; step(); rinc = 1'b0;
        check("pop_empty_ignored", 8'(rempty), 8'd1);

        // empty: commit with rinc held, only the commit lands
        rinc = 1'b1;
        write_pkt(128'({8'd5, 8'd6, 8'd0, 8'd9}), 4, 1'b1);
        rinc = 1'b0;
        check("sim_empty_rempty", 8'(rempty), 8'd0);
        check("sim_empty_wfull",  8'(wfull),  8'd0);
        read_at(4'd0);
        check("sim_empty_head", rdata, 8'd5);

        // two committed, one partial, then reset alongside a commit attempt
        write_pkt(128'({8'd11, 8'd12, 8'd0, 8'd13}), 4, 1'b1);
        write_pkt(128'({8'd31, 8'd32}), 2, 1'b0);
        rst = 1'b1; waddr_in = 4'd2; wdata = 8'd4; winc = 1'b1;
        step();
        rst = 1'b0; winc = 1'b0;
        check("midrst_rempty", 8'(rempty), 8'd1);
        check("midrst_wfull",  8'(wfull),  8'd0);
        check("midrst_rdata",  rdata,      8'd0);

        write_pkt(128'({8'd21, 8'd22, 8'd23}), 3, 1'b0);
        read_at(4'd0);
        check("uncommitted_rdata",  rdata,        8'd0);
        check("uncommitted_rempty", 8'(rempty),   8'd1);

`ifdef FIFO_LEN_CHECK_EN
        rst = 1'b1; step(); rst = 1'b0;
        write_pkt(128'({8'd10, 8'd160, 8'd3, 8'd0, 8'd1}), 5, 1'b0);
        waddr_in = 4'd5; wdata = 8'd15; winc = 1'b1;
        step();
        winc = 1'b0;
        check("len_short_rempty", 8'(rempty), 8'd1);
        waddr_in = 4'd6; wdata = 8'd15; winc = 1'b1;
        step();
        winc = 1'b0;
        check("len_ok_rempty", 8'(rempty), 8'd0);
        read_at(4'd1);
        check("len_ok_dest", rdata, 8'd160);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
